// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: instruction width, entry layout and PC increments.
package fetch_queue_pkg;

    localparam int ILEN       = 32;
    localparam int FQ_ENTRY_W = 2 * ILEN + 1;

    localparam logic [ILEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] PC_INC_16        = 32'd2;
    localparam logic [ILEN-1:0] PC_INC_32        = 32'd4;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            compressed;
    } fq_entry_t;

    function automatic logic [ILEN-1:0] pc_inc(input logic compressed);
        return compressed ? PC_INC_16 : PC_INC_32;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Realigner-facing and decode-facing signals of the fetch queue, plus the redirect from execute.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic            redirect_valid;
    logic [ILEN-1:0] redirect_pc;

    logic [ILEN-1:0] fa_pc;
    logic [ILEN-1:0] fa_pc_next;
    logic            fa_stall;
    logic            fa_step;
    logic            fa_ready;
    logic            fa_compressed;
    logic [ILEN-1:0] fa_inst;

    logic            id_valid;
    logic [ILEN-1:0] id_pc;
    logic [ILEN-1:0] id_inst;
    logic            id_compressed;
    logic            id_ready;

    // The fetch queue itself is the master; execute, realigner and decode together are the slave.
    modport master (
        input  redirect_valid, redirect_pc,
        output fa_pc, fa_pc_next, fa_stall, fa_step,
        input  fa_ready, fa_compressed, fa_inst,
        output id_valid, id_pc, id_inst, id_compressed,
        input  id_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  fa_pc, fa_pc_next, fa_stall, fa_step,
        output fa_ready, fa_compressed, fa_inst,
        input  id_valid, id_pc, id_inst, id_compressed,
        output id_ready
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Generic synchronous FIFO with flush; head is read straight from the registered storage (no bypass).
module fq_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Pointers are exactly log2(DEPTH) bits, so the +1 wraps mod DEPTH on its own.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Owns the fetch PC, drives the realigner controls and buffers fetched instructions for decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [ILEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master bus
);

    logic [ILEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] inc;
    logic [ILEN-1:0] target;
    logic            accept;
    logic            pop;
    logic            full;
    logic            empty;
    fq_entry_t       push_entry;
    fq_entry_t       head_entry;

    // Redirect wins over everything; the realigner outputs are gated off while in reset.
    always_comb begin
        inc        = pc_inc(bus.fa_compressed);
        target     = {bus.redirect_pc[ILEN-1:1], 1'b0};
        accept     = rst_n & bus.fa_ready & ~full & ~bus.redirect_valid;
        pop        = rst_n & ~empty & bus.id_ready & ~bus.redirect_valid;
        push_entry = '{pc: pc_q, inst: bus.fa_inst, compressed: bus.fa_compressed};
        if (bus.redirect_valid) begin
            pc_d = target;
        end else if (accept) begin
            pc_d = pc_q + inc;
        end else begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.fa_pc         = pc_q;
    assign bus.fa_pc_next    = pc_d;
    assign bus.fa_stall      = rst_n & full & ~bus.redirect_valid;
    assign bus.fa_step       = accept;
    assign bus.id_valid      = rst_n & ~empty;
    assign bus.id_pc         = head_entry.pc;
    assign bus.id_inst       = head_entry.inst;
    assign bus.id_compressed = head_entry.compressed;

    fq_fifo #(
        .WIDTH (FQ_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect_valid),
        .push  (accept),
        .pop   (pop),
        .wdata (push_entry),
        .head  (head_entry),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, ordering, full/stall, redirect, PC wrap and mid-run reset.
module tb_fetch_queue;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    fetch_queue_if bus_if ();

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic fr,
                                 input logic fc, input logic [31:0] fi, input logic ir);
        bus_if.redirect_valid = rv;
        bus_if.redirect_pc    = rpc;
        bus_if.fa_ready       = fr;
        bus_if.fa_compressed  = fc;
        bus_if.fa_inst        = fi;
        bus_if.id_ready       = ir;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset with the realigner claiming valid data: controls must stay quiet.
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h13, 1'b0);
        checkOutput("rst_step", bus_if.fa_step, 32'd0);
        checkOutput("rst_stall", bus_if.fa_stall, 32'd0);
        checkOutput("rst_id_valid", bus_if.id_valid, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("post_rst_pc", bus_if.fa_pc, 32'h0);
        checkOutput("post_rst_id_valid", bus_if.id_valid, 32'd0);
        checkOutput("post_rst_stall", bus_if.fa_stall, 32'd0);
        checkOutput("post_rst_step", bus_if.fa_step, 32'd0);

        // 32-bit then 16-bit instruction, decode sees both in order.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0013, 1'b0);
        checkOutput("seq_step0", bus_if.fa_step, 32'd1);
        checkOutput("seq_pc_next0", bus_if.fa_pc_next, 32'h4);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0001, 1'b1);
        checkOutput("seq_pc1", bus_if.fa_pc, 32'h4);
        checkOutput("seq_pc_next1", bus_if.fa_pc_next, 32'h6);
        checkOutput("seq_id_valid0", bus_if.id_valid, 32'd1);
        checkOutput("seq_id_pc0", bus_if.id_pc, 32'h0);
        checkOutput("seq_id_inst0", bus_if.id_inst, 32'h13);
        checkOutput("seq_id_c0", bus_if.id_compressed, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("seq_pc2", bus_if.fa_pc, 32'h6);
        checkOutput("seq_id_pc1", bus_if.id_pc, 32'h4);
        checkOutput("seq_id_inst1", bus_if.id_inst, 32'h1);
        checkOutput("seq_id_c1", bus_if.id_compressed, 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("seq_drained", bus_if.id_valid, 32'd0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Fill the queue with decode stalled; the 5th and 6th attempts must stall.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100 + i, 1'b0);
            checkOutput($sformatf("fill_step%0d", i), bus_if.fa_step, (i < 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fill_stall%0d", i), bus_if.fa_stall, (i < 4) ? 32'd0 : 32'd1);
            checkOutput($sformatf("fill_pc%0d", i), bus_if.fa_pc, (i < 4) ? 32'(4 * i) : 32'h10);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 1'b1);
        checkOutput("full_pop_step", bus_if.fa_step, 32'd0);
        checkOutput("full_pop_stall", bus_if.fa_stall, 32'd1);
        checkOutput("full_pop_pc_next", bus_if.fa_pc_next, 32'h10);
        checkOutput("full_pop_head", bus_if.id_pc, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h204, 1'b0);
        checkOutput("resume_step", bus_if.fa_step, 32'd1);
        checkOutput("resume_stall", bus_if.fa_stall, 32'd0);
        checkOutput("resume_pc", bus_if.fa_pc, 32'h10);
        checkOutput("resume_head", bus_if.id_pc, 32'h4);
        tick();

        // Drop to 3 entries, then redirect with decode ready and realigner valid.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h101, 1'b1, 1'b0, 32'h300, 1'b1);
        checkOutput("redir_pc_next", bus_if.fa_pc_next, 32'h100);
        checkOutput("redir_step", bus_if.fa_step, 32'd0);
        checkOutput("redir_stall", bus_if.fa_stall, 32'd0);
        checkOutput("redir_id_valid", bus_if.id_valid, 32'd1);
        checkOutput("redir_head", bus_if.id_pc, 32'h8);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("after_redir_id_valid", bus_if.id_valid, 32'd0);
        checkOutput("after_redir_pc", bus_if.fa_pc, 32'h100);

        // PC wrap at the top of the address space.
        applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h4501, 1'b0);
        checkOutput("wrap_pc", bus_if.fa_pc, 32'hFFFF_FFFE);
        checkOutput("wrap_pc_next", bus_if.fa_pc_next, 32'h0);
        checkOutput("wrap_step", bus_if.fa_step, 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("wrap_pc_after", bus_if.fa_pc, 32'h0);
        checkOutput("wrap_id_valid", bus_if.id_valid, 32'd1);
        checkOutput("wrap_id_pc", bus_if.id_pc, 32'hFFFF_FFFE);
        checkOutput("wrap_id_c", bus_if.id_compressed, 32'd1);
        checkOutput("wrap_id_inst", bus_if.id_inst, 32'h4501);

        // Realigner not ready: nothing moves.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput($sformatf("idle_step%0d", i), bus_if.fa_step, 32'd0);
            checkOutput($sformatf("idle_stall%0d", i), bus_if.fa_stall, 32'd0);
            checkOutput($sformatf("idle_pc%0d", i), bus_if.fa_pc, 32'h0);
            tick();
        end

        // Second entry queued, then a reset mid-operation discards both.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h33, 1'b0);
        tick();
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("midrst_id_valid_comb", bus_if.id_valid, 32'd0);
        checkOutput("midrst_pc_before", bus_if.fa_pc, 32'h4);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_id_valid", bus_if.id_valid, 32'd0);
        checkOutput("midrst_pc", bus_if.fa_pc, 32'h0);
        checkOutput("midrst_id_inst", bus_if.id_inst, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
